// File: rtl/frame_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_mem : 2**A x S word memory, read-first, one-cycle bulk clear via
//             per-word valid bits. Rev 1.0
// ----------------------------------------------------------------------------
module frame_mem #(
  parameter int A = 9,
  parameter int S = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [A-1:0] address_write,
  input  logic [S-1:0] data_write,
  input  logic         wren,
  input  logic [A-1:0] address_read,
  output logic [S-1:0] data_read
);

  localparam int DEPTH = 2 ** A;

  logic [S-1:0]     r_mem [DEPTH];
  logic [S-1:0]     r_rd_data;
  logic [DEPTH-1:0] r_valid;
  logic             r_rd_valid;

  // Data array carries no reset so it maps onto block RAM; the non-blocking
  // read alongside the write gives read-first behaviour on a collision.
  always_ff @(posedge clock) begin
    if (!reset && wren) begin
      r_mem[address_write] <= data_write;
    end
    r_rd_data <= r_mem[address_read];
  end

  // Valid bits live in flops so a single reset edge invalidates every word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= r_valid[address_read];
      if (wren) begin
        r_valid[address_write] <= 1'b1;
      end
    end
  end

  // Invalid words never expose the uninitialised RAM contents.
  assign data_read = r_rd_valid ? r_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_frame_mem.sv
`default_nettype none
// Bench for frame_mem: directed table, full-depth clear, randomized ping-pong
// traffic against an array model, and a hand-written bank swap sequence.
module tb_frame_mem;

  localparam int A = 9;
  localparam int S = 24;
  localparam int DEPTH = 2 ** A;

  logic         clock = 1'b0;
  logic         rst_a, rst_b, wren, sel;
  logic [A-1:0] address_write, address_read;
  logic [S-1:0] data_write, data_a, data_b;
  logic         wren_a, wren_b;

  assign wren_a = wren & ~sel;
  assign wren_b = wren & sel;

  always #5 clock = ~clock;

  frame_mem #(.A(A), .S(S)) u_a (
    .clock(clock), .reset(rst_a), .address_write(address_write),
    .data_write(data_write), .wren(wren_a), .address_read(address_read),
    .data_read(data_a)
  );

  frame_mem #(.A(A), .S(S)) u_b (
    .clock(clock), .reset(rst_b), .address_write(address_write),
    .data_write(data_write), .wren(wren_b), .address_read(address_read),
    .data_read(data_b)
  );

  // Reference model: one array of words plus a written-since-clear flag per bank.
  logic [S-1:0]     mm [2][DEPTH];
  bit   [DEPTH-1:0] mv [2];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit           rst;
    bit           we;
    logic [A-1:0] aw;
    logic [S-1:0] dw;
    logic [A-1:0] ar;
    logic [S-1:0] exp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [S-1:0] act, input logic [S-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, predict from the model's pre-edge state, update model.
  task automatic cycle(input bit ra, input bit rb, input bit we, input bit s,
                       input logic [A-1:0] aw, input logic [S-1:0] dw,
                       input logic [A-1:0] ar,
                       output logic [S-1:0] ea, output logic [S-1:0] eb);
    rst_a = ra; rst_b = rb; wren = we; sel = s;
    address_write = aw; data_write = dw; address_read = ar;
    ea = (!ra && mv[0][ar]) ? mm[0][ar] : '0;
    eb = (!rb && mv[1][ar]) ? mm[1][ar] : '0;
    if (ra) mv[0] = '0;
    else if (we && !s) begin mm[0][aw] = dw; mv[0][aw] = 1'b1; end
    if (rb) mv[1] = '0;
    else if (we && s) begin mm[1][aw] = dw; mv[1][aw] = 1'b1; end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [S-1:0] ea, eb;
    logic [A-1:0] ra_addr, wa_addr;

    mv[0] = '0; mv[1] = '0;
    rst_a = 1'b0; rst_b = 1'b0; wren = 1'b0; sel = 1'b0;
    address_write = '0; data_write = '0; address_read = '0;

    tbl[0]  = '{1'b1, 1'b0, 9'd0, 24'h000000, 9'd0,   24'h000000};
    tbl[1]  = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd0,   24'h000000};
    tbl[2]  = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd5,   24'h000000};
    tbl[3]  = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd511, 24'h000000};
    tbl[4]  = '{1'b0, 1'b1, 9'd3, 24'hABCDEF, 9'd0,   24'h000000};
    tbl[5]  = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd3,   24'hABCDEF};
    tbl[6]  = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd4,   24'h000000};
    tbl[7]  = '{1'b0, 1'b1, 9'd7, 24'h111111, 9'd3,   24'hABCDEF};
    tbl[8]  = '{1'b0, 1'b1, 9'd7, 24'h123456, 9'd7,   24'h111111};
    tbl[9]  = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd7,   24'h123456};
    tbl[10] = '{1'b1, 1'b1, 9'd2, 24'hFFFFFF, 9'd7,   24'h000000};
    tbl[11] = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd2,   24'h000000};
    tbl[12] = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd7,   24'h000000};
    tbl[13] = '{1'b0, 1'b1, 9'd2, 24'h000042, 9'd2,   24'h000000};
    tbl[14] = '{1'b0, 1'b0, 9'd0, 24'h000000, 9'd2,   24'h000042};

    @(posedge clock);
    #1;

    // Directed table: reset reads, write/read, read-first, reset beats write.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rst, tbl[i].rst, tbl[i].we, 1'b0, tbl[i].aw, tbl[i].dw, tbl[i].ar, ea, eb);
      check($sformatf("table[%0d]", i), data_a, tbl[i].exp);
    end

    // Fill every word, clear in one cycle, confirm all words read zero.
    for (int i = 0; i < DEPTH; i++) begin
      wa_addr = A'(i);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, wa_addr, {15'd0, wa_addr} ^ 24'h5A5A5A, wa_addr, ea, eb);
      check("fill", data_a, ea);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 9'd300, ea, eb);
    check("fill_readback", data_a, 24'h5A5A5A ^ 24'd300);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, ea, eb);
    check("clear_cycle", data_a, 24'h000000);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, A'(i), ea, eb);
      check($sformatf("cleared[%0d]", i), data_a, 24'h000000);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 9'd9, 24'h000001, 9'd9, ea, eb);
    check("rewrite9_same_edge", data_a, 24'h000000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 9'd9, ea, eb);
    check("rewrite9", data_a, 24'h000001);

    // Randomized traffic on both banks; narrow addresses force collisions.
    for (int i = 0; i < 3000; i++) begin
      ra_addr = ($urandom % 4 == 0) ? A'($urandom) : A'($urandom % 16);
      wa_addr = ($urandom % 4 == 0) ? A'($urandom) : A'($urandom % 16);
      cycle(($urandom % 40) == 0, ($urandom % 40) == 0, $urandom % 2 == 1,
            $urandom % 2 == 1, wa_addr, S'($urandom), ra_addr, ea, eb);
      check("rand_a", data_a, ea);
      check("rand_b", data_b, eb);
    end

    // Ping-pong: bank A renders frame 1 while B is idle.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, ea, eb);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b0, 1'b1, 1'b0, A'(i), 24'h100000 | i, '0, ea, eb);
    // Swap: B cleared and rendered with frame 2 while A is scanned out.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 9'd8, ea, eb);
    check("pp_b_cleared", data_b, 24'h000000);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, A'(i), 24'h200000 | i, A'(i), ea, eb);
      check($sformatf("pp_scan_a[%0d]", i), data_a, 24'h100000 | i);
    end
    // Swap back: A cleared, B scanned out.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, ea, eb);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, A'(i), ea, eb);
      check($sformatf("pp_a_cleared[%0d]", i), data_a, 24'h000000);
      check($sformatf("pp_scan_b[%0d]", i), data_b, 24'h200000 | i);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 9'd8, ea, eb);
    check("pp_b_unwritten", data_b, 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
